// File: rtl/sample_unpacker_pkg.sv
// Shared definitions for the sample packer, the unpacker and the host decode model.
// Mode encodings, group geometry and the 12-bit sample layout live here.
package sample_unpacker_pkg;

    typedef enum logic [1:0] {
        MODE_IQ2 = 2'd0,
        MODE_I8  = 2'd1,
        MODE_Q8  = 2'd2
    } mode_e;

    localparam int WORDS_PER_GROUP_IQ2 = 3;
    localparam int WORDS_PER_GROUP_8B  = 2;
    localparam int SAMPLE_W            = 12;

    // Mode 0 sample: 2-bit sign/quadrature pairs for channels 1..3, ch1 in the MSBs.
    typedef struct packed {
        logic [1:0] ch1_si;
        logic [1:0] ch1_sq;
        logic [1:0] ch2_si;
        logic [1:0] ch2_sq;
        logic [1:0] ch3_si;
        logic [1:0] ch3_sq;
    } iq2_sample_t;

    typedef struct packed {
        logic [1:0]          mode;
        logic [SAMPLE_W-1:0] smp;
    } sample_t;

    // Packet length in words; unknown modes are framed like mode 0.
    function automatic int pkt_words(input logic [7:0] m, input int groups);
        if (m == 8'(MODE_I8) || m == 8'(MODE_Q8)) begin
            return WORDS_PER_GROUP_8B * groups;
        end
        return WORDS_PER_GROUP_IQ2 * groups;
    endfunction

endpackage

// File: rtl/sample_unpacker_if.sv
// Packed word stream in, recovered sample stream out; master drives words, slave is the unpacker.
// Neither side has backpressure: words and samples are accepted whenever valid.
interface sample_unpacker_if;
    import sample_unpacker_pkg::*;

    logic [15:0]         data;
    logic                en;
    logic                packet_end;
    logic                out_valid;
    logic [SAMPLE_W-1:0] out_sample;
    logic [1:0]          out_mode;

    modport master (
        output data, en, packet_end,
        input  out_valid, out_sample, out_mode
    );

    modport slave (
        input  data, en, packet_end,
        output out_valid, out_sample, out_mode
    );

endinterface

// File: rtl/sample_fifo_2w1r.sv
// Sample FIFO taking up to two pushes (push0 first) and one pop per cycle; written data readable next cycle.
// No backpressure: pushes beyond the free space (counting this cycle's pop) are dropped and flagged on drop.
module sample_fifo_2w1r
    import sample_unpacker_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push0_vld,
    input  sample_t push0_dat,
    input  logic    push1_vld,
    input  sample_t push1_dat,
    input  logic    pop,
    output sample_t head_dat,
    output logic    empty,
    output logic    drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sample_t        mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  space;
    logic           pop_ok;
    logic           acc0;
    logic           acc1;

    assign pop_ok   = pop && (count != '0);
    assign space    = CW'(DEPTH) - count + CW'(pop_ok);
    assign acc0     = push0_vld && (space != '0);
    assign acc1     = push1_vld && (space > CW'(acc0));
    assign drop     = (push0_vld && !acc0) || (push1_vld && !acc1);
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (acc0) begin
            mem[wr_ptr] <= push0_dat;
        end
        if (acc1) begin
            mem[wr_ptr + PW'(acc0)] <= push1_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(acc0) + PW'(acc1);
            rd_ptr <= rd_ptr + PW'(pop_ok);
            count  <= count + CW'(acc0) + CW'(acc1) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/sample_unpacker.sv
// Unpacks the mode 0/1/2 word stream into one sample per cycle and checks packet framing.
// Samples appear two cycles after their word; no backpressure, FIFO overflow drops samples and sets a sticky flag.
module sample_unpacker
    import sample_unpacker_pkg::*;
#(
    parameter int GROUPS_PER_PACKET = 240,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    sample_unpacker_if.slave   bus,
    input  logic [7:0]         mode,
    input  logic               clear_errors,
    output logic [15:0]        packet_count,
    output logic               length_error,
    output logic               overflow_error,
    output logic               in_sync
);

    localparam int CNT_W = $clog2(WORDS_PER_GROUP_IQ2 * GROUPS_PER_PACKET);

    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]          state;
    logic [CNT_W-1:0]    word_cnt;
    logic [1:0]          grp_pos;
    logic [7:0]          mode_lat;
    logic [7:0]          hold;

    logic                pkt_start;
    logic [7:0]          cur_mode;
    logic [CNT_W-1:0]    exp_last;
    logic                at_last;
    logic                run_word;
    logic                good_end;
    logic                err_end;
    logic                err_long;
    logic                accept;
    logic                unpack;

    logic                push0_vld;
    logic                push1_vld;
    sample_t             push0_dat;
    sample_t             push1_dat;
    sample_t             head;
    logic                fifo_empty;
    logic                fifo_drop;

    logic                out_valid_q;
    logic [SAMPLE_W-1:0] out_sample_q;
    logic [1:0]          out_mode_q;

    // The first word of a packet is decoded with the live mode; later words use the latched copy.
    assign pkt_start = (word_cnt == '0);
    assign cur_mode  = pkt_start ? mode : mode_lat;
    assign exp_last  = CNT_W'(pkt_words(cur_mode, GROUPS_PER_PACKET) - 1);
    assign at_last   = (word_cnt == exp_last);
    assign run_word  = (state == ST_RUN) && bus.en;
    assign good_end  = run_word && bus.packet_end && at_last;
    assign err_end   = run_word && bus.packet_end && !at_last;
    assign err_long  = run_word && !bus.packet_end && at_last;
    assign accept    = run_word && !err_end && !err_long;
    assign unpack    = accept && (cur_mode <= 8'(MODE_Q8));

    // Mode 0 group of 48 bits: W0={S0,S1[11:8]}, W1={S1[7:0],S2[11:4]}, W2={S2[3:0],S3}.
    always_comb begin
        push0_vld = 1'b0;
        push1_vld = 1'b0;
        push0_dat = '0;
        push1_dat = '0;
        if (unpack) begin
            push0_vld = 1'b1;
            if (cur_mode == 8'(MODE_IQ2)) begin
                if (grp_pos == 2'd0) begin
                    push0_dat = {cur_mode[1:0], bus.data[15:4]};
                end else if (grp_pos == 2'd1) begin
                    push0_dat = {cur_mode[1:0], hold[3:0], bus.data[15:8]};
                end else begin
                    push0_dat = {cur_mode[1:0], hold, bus.data[15:12]};
                    push1_vld = 1'b1;
                    push1_dat = {cur_mode[1:0], bus.data[11:0]};
                end
            end else begin
                push0_dat = {cur_mode[1:0], 4'd0, bus.data[15:8]};
                push1_vld = 1'b1;
                push1_dat = {cur_mode[1:0], 4'd0, bus.data[7:0]};
            end
        end
    end

    sample_fifo_2w1r #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push0_vld (push0_vld),
        .push0_dat (push0_dat),
        .push1_vld (push1_vld),
        .push1_dat (push1_dat),
        .pop       (!fifo_empty),
        .head_dat  (head),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_SYNC;
            word_cnt       <= '0;
            grp_pos        <= '0;
            mode_lat       <= '0;
            hold           <= '0;
            packet_count   <= '0;
            length_error   <= 1'b0;
            overflow_error <= 1'b0;
            out_valid_q    <= 1'b0;
            out_sample_q   <= '0;
            out_mode_q     <= '0;
        end else begin
            length_error   <= (length_error && !clear_errors) || err_end || err_long;
            overflow_error <= (overflow_error && !clear_errors) || fifo_drop;
            out_valid_q    <= !fifo_empty;
            if (!fifo_empty) begin
                out_sample_q <= head.smp;
                out_mode_q   <= head.mode;
            end
            if (unpack) begin
                hold <= bus.data[7:0];
            end
            if (state == ST_SYNC) begin
                if (bus.en && bus.packet_end) begin
                    state    <= ST_RUN;
                    word_cnt <= '0;
                    grp_pos  <= '0;
                end
            end else if (bus.en) begin
                if (pkt_start) begin
                    mode_lat <= mode;
                end
                // A misplaced packet_end is itself a valid boundary, so it resyncs in place.
                if (good_end || err_end) begin
                    word_cnt <= '0;
                    grp_pos  <= '0;
                    if (good_end) begin
                        packet_count <= packet_count + 16'd1;
                    end
                end else if (err_long) begin
                    state    <= ST_SYNC;
                    word_cnt <= '0;
                    grp_pos  <= '0;
                end else begin
                    word_cnt <= word_cnt + CNT_W'(1);
                    grp_pos  <= (grp_pos == 2'd2) ? 2'd0 : grp_pos + 2'd1;
                end
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_sample = out_sample_q;
    assign bus.out_mode   = out_mode_q;
    assign in_sync        = (state == ST_RUN);

endmodule

// File: tb/tb_sample_unpacker.sv
// Directed stimulus with a scoreboard queue; a negedge monitor pops and compares every output sample.
module tb_sample_unpacker;
    import sample_unpacker_pkg::*;

    localparam int G      = 240;
    localparam int M0_LEN = 3 * G;
    localparam int M8_LEN = 2 * G;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  mode;
    logic        clear_errors;
    logic [15:0] packet_count;
    logic        length_error;
    logic        overflow_error;
    logic        in_sync;

    sample_unpacker_if bus ();

    sample_unpacker #(
        .GROUPS_PER_PACKET (G),
        .FIFO_DEPTH        (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .mode           (mode),
        .clear_errors   (clear_errors),
        .packet_count   (packet_count),
        .length_error   (length_error),
        .overflow_error (overflow_error),
        .in_sync        (in_sync)
    );

    always #5 clk = ~clk;

    logic [13:0] exp_q[$];
    int          checks   = 0;
    int          errors   = 0;
    bit          lossy    = 1'b0;
    int          dropped  = 0;
    int          received = 0;
    logic [13:0] mon_got;
    logic [13:0] mon_exp;

    // In lossy mode, expected entries that never show up are counted as dropped.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.out_valid === 1'b1) begin
            mon_got = {bus.out_mode, bus.out_sample};
            if (lossy) begin
                while (exp_q.size() > 0 && exp_q[0] !== mon_got) begin
                    void'(exp_q.pop_front());
                    dropped++;
                end
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sample: unexpected output got=%h, nothing expected", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_exp !== mon_got) begin
                    errors++;
                    $display("FAIL sample: got=%h expected=%h", mon_got, mon_exp);
                end else begin
                    received++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [11:0] m0_smp(input int base, input int g, input int j);
        return 12'((base + g * 4 + j) * 173);
    endfunction

    function automatic logic [15:0] m0_word(input int base, input int g, input int p);
        logic [11:0] s0, s1, s2, s3;
        s0 = m0_smp(base, g, 0);
        s1 = m0_smp(base, g, 1);
        s2 = m0_smp(base, g, 2);
        s3 = m0_smp(base, g, 3);
        case (p)
            0:       return {s0, s1[11:8]};
            1:       return {s1[7:0], s2[11:4]};
            default: return {s2[3:0], s3};
        endcase
    endfunction

    task automatic put(input logic [15:0] d, input bit pe);
        bus.data       = d;
        bus.en         = 1'b1;
        bus.packet_end = pe;
        @(posedge clk);
        #1;
        bus.en         = 1'b0;
        bus.packet_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Words first..last of a mode 0 packet; gap inserts the streamer's idle cycle after each group.
    task automatic send_m0(input int base, input int first, input int last, input int pe_w,
                           input bit gap, input bit expect_out, input int chg_w,
                           input logic [7:0] chg_mode);
        int g, p;
        bit pe;
        for (int w = first; w <= last; w++) begin
            g  = w / 3;
            p  = w % 3;
            pe = (w == pe_w);
            if (w == chg_w) mode = chg_mode;
            if (expect_out && (pe == (w == M0_LEN - 1))) begin
                if (p == 0) exp_q.push_back({2'd0, m0_smp(base, g, 0)});
                if (p == 1) exp_q.push_back({2'd0, m0_smp(base, g, 1)});
                if (p == 2) begin
                    exp_q.push_back({2'd0, m0_smp(base, g, 2)});
                    exp_q.push_back({2'd0, m0_smp(base, g, 3)});
                end
            end
            put(m0_word(base, g, p), pe);
            if (gap && p == 2) idle(1);
        end
    endtask

    task automatic send_m8(input int first, input int last, input int pe_w, input bit expect_out);
        logic [7:0] kb;
        bit pe;
        for (int k = first; k <= last; k++) begin
            kb = 8'(k);
            pe = (k == pe_w);
            if (expect_out && (pe == (k == M8_LEN - 1))) begin
                exp_q.push_back({mode[1:0], 4'h0, kb});
                exp_q.push_back({mode[1:0], 4'h0, ~kb});
            end
            put({kb, ~kb}, pe);
            idle(1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d samples outstanding, required 0", exp_q.size());
        end
        idle(4);
    endtask

    task automatic pulse_reset();
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
    endtask

    initial begin
        reset_n        = 1'b1;
        mode           = 8'd0;
        clear_errors   = 1'b0;
        bus.data       = 16'h0;
        bus.en         = 1'b0;
        bus.packet_end = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_sample", 32'(bus.out_sample), 32'd0);
        chk("rst out_mode", 32'(bus.out_mode), 32'd0);
        chk("rst packet_count", 32'(packet_count), 32'd0);
        chk("rst length_error", 32'(length_error), 32'd0);
        chk("rst overflow_error", 32'(overflow_error), 32'd0);
        chk("rst in_sync", 32'(in_sync), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        idle(1);

        // Resync, then the hand-computed mode 0 group and the rest of that packet.
        put(16'h0000, 1'b1);
        chk("in_sync after resync", 32'(in_sync), 32'd1);
        mode = 8'd0;
        exp_q.push_back({2'd0, 12'hABC});
        put(16'hABC1, 1'b0);
        exp_q.push_back({2'd0, 12'h123});
        put(16'h2345, 1'b0);
        exp_q.push_back({2'd0, 12'h456});
        exp_q.push_back({2'd0, 12'h789});
        put(16'h6789, 1'b0);
        idle(1);
        send_m0(5, 3, M0_LEN - 1, M0_LEN - 1, 1'b1, 1'b1, -1, 8'd0);
        drain();
        chk("mode0 packet_count", 32'(packet_count), 32'd1);
        chk("mode0 length_error", 32'(length_error), 32'd0);
        chk("mode0 overflow_error", 32'(overflow_error), 32'd0);

        // Full mode 1 packet.
        mode = 8'd1;
        send_m8(0, M8_LEN - 1, M8_LEN - 1, 1'b1);
        drain();
        chk("mode1 packet_count", 32'(packet_count), 32'd2);
        chk("mode1 length_error", 32'(length_error), 32'd0);

        // Early packet_end on word 500, recovery, sticky flag and clear behaviour.
        mode = 8'd0;
        send_m0(20, 0, 500, 500, 1'b1, 1'b1, -1, 8'd0);
        chk("early end length_error", 32'(length_error), 32'd1);
        chk("early end in_sync", 32'(in_sync), 32'd1);
        send_m0(30, 0, M0_LEN - 1, M0_LEN - 1, 1'b1, 1'b1, -1, 8'd0);
        drain();
        chk("recovered packet_count", 32'(packet_count), 32'd3);
        chk("length_error sticky", 32'(length_error), 32'd1);
        clear_errors = 1'b1;
        put(16'h1234, 1'b1);
        clear_errors = 1'b0;
        chk("clear with new error", 32'(length_error), 32'd1);
        chk("in_sync after word0 end", 32'(in_sync), 32'd1);
        clear_errors = 1'b1;
        idle(1);
        clear_errors = 1'b0;
        chk("clear_errors", 32'(length_error), 32'd0);

        // Stream joined mid-packet after reset.
        pulse_reset();
        @(negedge clk) reset_n = 1'b1;
        idle(1);
        mode = 8'd0;
        send_m0(7, 300, M0_LEN - 2, -1, 1'b1, 1'b0, -1, 8'd0);
        chk("mid-packet in_sync", 32'(in_sync), 32'd0);
        send_m0(7, M0_LEN - 1, M0_LEN - 1, M0_LEN - 1, 1'b0, 1'b0, -1, 8'd0);
        chk("first end in_sync", 32'(in_sync), 32'd1);
        send_m0(8, 0, M0_LEN - 1, M0_LEN - 1, 1'b1, 1'b1, -1, 8'd0);
        drain();
        chk("after join packet_count", 32'(packet_count), 32'd1);

        // Mode change mid-packet only applies from the next packet.
        send_m0(40, 0, M0_LEN - 1, M0_LEN - 1, 1'b1, 1'b1, 100, 8'd1);
        drain();
        chk("mode change packet_count", 32'(packet_count), 32'd2);
        chk("mode change length_error", 32'(length_error), 32'd0);
        send_m8(0, M8_LEN - 1, M8_LEN - 1, 1'b1);
        drain();
        chk("next packet mode1 count", 32'(packet_count), 32'd3);

        // Back-to-back mode 0 words outrun the single pop per cycle.
        mode     = 8'd0;
        lossy    = 1'b1;
        dropped  = 0;
        received = 0;
        send_m0(50, 0, 11, -1, 1'b0, 1'b1, -1, 8'd0);
        idle(20);
        dropped += exp_q.size();
        exp_q.delete();
        lossy = 1'b0;
        chk("overflow_error", 32'(overflow_error), 32'd1);
        chk("overflow drops seen", 32'(dropped >= 1), 32'd1);
        chk("overflow length_error", 32'(length_error), 32'd0);

        // Asynchronous reset mid-packet with samples in flight.
        send_m0(50, 12, 13, -1, 1'b0, 1'b1, -1, 8'd0);
        pulse_reset();
        chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("async rst out_sample", 32'(bus.out_sample), 32'd0);
        chk("async rst out_mode", 32'(bus.out_mode), 32'd0);
        chk("async rst packet_count", 32'(packet_count), 32'd0);
        chk("async rst overflow_error", 32'(overflow_error), 32'd0);
        chk("async rst in_sync", 32'(in_sync), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        idle(5);
        mode = 8'd1;
        send_m8(100, 101, -1, 1'b0);
        send_m8(102, 102, 102, 1'b0);
        send_m8(0, M8_LEN - 1, M8_LEN - 1, 1'b1);
        drain();
        chk("post reset packet_count", 32'(packet_count), 32'd1);
        chk("post reset in_sync", 32'(in_sync), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
